// File: rtl/display_seq_pkg.sv
// Shared types and constants for the HEX message display sequencer.
// Holds the state encoding, message addresses and result latch type.
package display_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEVEL = 2'd1,
        S_BLINK = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    typedef enum logic {
        RES_WIN  = 1'b0,
        RES_LOSE = 1'b1
    } result_e;

    localparam logic [1:0] ADDR_NIVEL  = 2'b00;
    localparam logic [1:0] ADDR_VENCEU = 2'b01;
    localparam logic [1:0] ADDR_PERDEU = 2'b10;
    localparam logic [1:0] ADDR_BLANK  = 2'b11;

    // Message address for a latched game result.
    function automatic logic [1:0] result_addr(input result_e r);
        return (r == RES_LOSE) ? ADDR_PERDEU : ADDR_VENCEU;
    endfunction

endpackage

// File: rtl/display_sequencer_seq_timer.sv
// Up-counter with synchronous clear and enable.
// Flags done when the count reaches a runtime terminal value.
module seq_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == term_i);

endmodule

// File: rtl/display_sequencer.sv
// Sequences game events into level banner and blinking result messages.
// Drives the message address and level bit of the HEX message memory.
module display_sequencer
    import display_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int BLINK_HALF  = 25_000_000,
    parameter int BLINK_COUNT = 3,
    parameter int CNT_W       = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       nivel,
    input  logic       venceu,
    input  logic       perdeu,
    input  logic       limpar,
    output logic [1:0] displayAddr,
    output logic       nivel_disp,
    output logic       busy,
    output logic [1:0] db_estado
);

    localparam int PAIR_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(BLINK_COUNT - 1);
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(BLINK_HALF - 1);

    state_e            state_q;
    logic              phase_q;
    logic [PAIR_W-1:0] pair_q;
    result_e           result_q;
    logic              nivel_q;

    logic             ev_clear;
    logic             ev_start;
    logic             ev_result;
    logic             timed;
    logic             tmr_clr;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_term;

    // Event arbitration: limpar > iniciar > perdeu > venceu.
    always_comb begin
        timed     = (state_q == S_LEVEL) || (state_q == S_BLINK);
        ev_clear  = limpar && (state_q != S_IDLE);
        ev_start  = !limpar && iniciar;
        ev_result = !limpar && !iniciar && (perdeu || venceu) &&
                    ((state_q == S_IDLE) || (state_q == S_LEVEL));
        tmr_clr   = ev_clear || ev_start || ev_result ||
                    (timed && tmr_done);
        tmr_term  = (state_q == S_LEVEL) ? HOLD_TERM : HALF_TERM;
    end

    seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (tmr_clr),
        .en_i   (timed),
        .term_i (tmr_term),
        .done_o (tmr_done)
    );

    // Main sequencing FSM with phase, pair and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            phase_q  <= 1'b0;
            pair_q   <= '0;
            result_q <= RES_WIN;
            nivel_q  <= 1'b0;
        end else if (ev_clear) begin
            state_q <= S_IDLE;
        end else if (ev_start) begin
            state_q <= S_LEVEL;
            nivel_q <= nivel;
        end else if (ev_result) begin
            state_q  <= S_BLINK;
            phase_q  <= 1'b1;
            pair_q   <= '0;
            result_q <= perdeu ? RES_LOSE : RES_WIN;
        end else if (tmr_done) begin
            case (state_q)
                S_LEVEL: state_q <= S_IDLE;
                S_BLINK: begin
                    if (phase_q) begin
                        phase_q <= 1'b0;
                    end else if (pair_q == PAIR_LAST) begin
                        state_q <= S_HOLD;
                    end else begin
                        phase_q <= 1'b1;
                        pair_q  <= pair_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore output decode from registered state.
    always_comb begin
        displayAddr = ADDR_BLANK;
        case (state_q)
            S_LEVEL: displayAddr = ADDR_NIVEL;
            S_BLINK: displayAddr = phase_q ? result_addr(result_q)
                                           : ADDR_BLANK;
            S_HOLD:  displayAddr = result_addr(result_q);
            default: displayAddr = ADDR_BLANK;
        endcase
    end

    assign nivel_disp = nivel_q;
    assign busy       = (state_q != S_IDLE);
    assign db_estado  = state_q;

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
Controller that drives the 2-bit message address and level bit of the six-digit HEX message memory (00 = "nivel0/1", 01 = "venceu", 10 = "perdeu", 11 = blank).
Sequences game events into timed display behaviour:
- level banner shown for a fixed time on game start;
- win/lose message blinks, then holds steady until cleared.
Sits between the game control FSM and the display memory.

Parameters:
HOLD_CYCLES, 50_000_000, clock cycles the level banner stays on screen (>=2)
BLINK_HALF, 25_000_000, clock cycles per blink half-period, on or off (>=1)
BLINK_COUNT, 3, number of on/off blink pairs before steady hold (>=1)
CNT_W, 26, counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, BLINK_HALF)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
iniciar  input  1  one-cycle pulse: new game/level start
nivel  input  1  level to show; sampled only when iniciar is accepted
venceu  input  1  one-cycle pulse: game won
perdeu  input  1  one-cycle pulse: game lost
limpar  input  1  one-cycle pulse: clear display to blank
displayAddr  output  2  message select to display memory
nivel_disp  output  1  latched level bit to display memory
busy  output  1  high whenever state != IDLE
db_estado  output  2  current state encoding, for debug HEX

Behaviour:
- Reset: while reset==0, asynchronously force:
  - state=IDLE, displayAddr=2'b11, nivel_disp=0, busy=0, db_estado=0;
  - counters cleared, blink-pair count cleared, result latch=0.
  - Reset applied mid-sequence aborts immediately.
- States and encoding: IDLE=0, LEVEL=1, BLINK=2, HOLD=3.
- Outputs are Moore, decoded from registered state/phase/result.
  - Event sampled at rising edge N is visible on displayAddr after edge N.
  - The display memory adds one more cycle.
- Input priority each cycle, all states: limpar > iniciar > perdeu > venceu.
- limpar: go to IDLE from any state. Ignored in IDLE.
- iniciar: go to LEVEL from any state, including LEVEL.
  - Latch nivel into nivel_disp.
  - Clear counter.
  - Re-trigger in LEVEL restarts the full hold time.
- perdeu/venceu:
  - From IDLE or LEVEL: go to BLINK, phase=on, counter=0, pair count=0.
  - Result latch = LOSE if perdeu, else WIN. Same-cycle perdeu+venceu gives LOSE.
  - In BLINK or HOLD: ignored; the first result stands until limpar or iniciar.
- IDLE: displayAddr=11.
- LEVEL:
  - displayAddr=00, nivel_disp=latched value.
  - Counter increments each cycle. At counter==HOLD_CYCLES-1, next state is IDLE.
  - Banner is visible for exactly HOLD_CYCLES cycles.
- BLINK:
  - On phase: displayAddr=01 (WIN) or 10 (LOSE). Off phase: displayAddr=11.
  - Phase toggles when counter==BLINK_HALF-1; counter then resets to 0.
  - Pair count increments at each off-to-on boundary.
  - At the end of the BLINK_COUNT-th off phase, go to HOLD instead of toggling.
- HOLD: displayAddr = result message, steady; leaves only via limpar or iniciar.
- nivel_disp holds its last latched value outside LEVEL. It changes only on accepted iniciar or reset.
- Counter never wraps: all terminal compares use ==, and the counter is cleared on every state entry.

Decomposition:
- Package display_seq_pkg:
  - state encodings (IDLE/LEVEL/BLINK/HOLD);
  - address constants ADDR_NIVEL=2'b00, ADDR_VENCEU=2'b01, ADDR_PERDEU=2'b10, ADDR_BLANK=2'b11;
  - result enum WIN/LOSE.
- One sub-module: seq_timer.
  - CNT_W-bit up-counter with clear and enable.
  - Outputs done when count equals a runtime terminal value (HOLD_CYCLES-1 or BLINK_HALF-1).
  - Same asynchronous active-low reset.

Test Plan (HOLD_CYCLES=4, BLINK_HALF=2, BLINK_COUNT=2):
- Reset low with pulses active -> displayAddr=11, nivel_disp=0, busy=0, db_estado=0. Release reset -> unchanged, no spurious transition.
- iniciar with nivel=1; toggle nivel to 0 two cycles later -> displayAddr=00 and nivel_disp=1 for exactly 4 cycles, then 11, busy=0. Re-pulse iniciar at cycle 3 -> banner lasts 3+4 cycles total.
- venceu from IDLE -> displayAddr sequence 01,01,11,11,01,01,11,11, then 01 steady, db_estado=3. limpar -> 11 next cycle.
- venceu on cycle 2 of LEVEL -> displayAddr=01 immediately, BLINK entered. perdeu during BLINK -> sequence unchanged (still 01).
- venceu+perdeu same cycle -> blink shows 10. In HOLD, limpar+iniciar same cycle -> IDLE (11), nivel_disp not updated.
- Pull reset low mid-BLINK, asynchronous to clock -> displayAddr=11 before next edge. Release, then venceu -> blink restarts from pair 0, on phase.
